// File: rtl/non_max_suppression_if.sv
// FIFO-side handshakes of the non-maximum suppression stage.
// The slave modport is the stage itself; master is the surrounding FIFO/environment side.
interface non_max_suppression_if;
    logic       in_rd_en;
    logic       in_empty;
    logic [9:0] in_dout;
    logic       out_wr_en;
    logic       out_full;
    logic [7:0] out_din;

    modport master (
        input  in_rd_en,
        output in_empty,
        output in_dout,
        input  out_wr_en,
        output out_full,
        input  out_din
    );

    modport slave (
        output in_rd_en,
        input  in_empty,
        input  in_dout,
        output out_wr_en,
        input  out_full,
        output out_din
    );
endinterface

// File: rtl/non_max_suppression.sv
// Canny non-maximum suppression over a line-buffered 3x3 window of {dir, mag} words.
// Define NMS_STRICT_EN to use a strict keep test, which suppresses plateaus.
module non_max_suppression #(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540
) (
    input  logic                 clock,
    input  logic                 reset,
    non_max_suppression_if.slave bus
);
    localparam int SHIFT_REG_LEN = 2 * WIDTH + 3;
    localparam int PIXEL_COUNT   = WIDTH * HEIGHT;
    localparam int PAD_START     = PIXEL_COUNT - 1 - (WIDTH + 2);
    localparam int COL_W         = $clog2(WIDTH);
    localparam int ROW_W         = $clog2(HEIGHT + 1);
    localparam int CNT_W         = $clog2(WIDTH + 3);
    localparam int IDX_W         = $clog2(PIXEL_COUNT + 1);

    typedef enum logic [1:0] {
        S_PROLOGUE = 2'd0,
        S_NMS      = 2'd1,
        S_OUTPUT   = 2'd2
    } state_t;

    state_t           r_state, w_state_next;
    logic [9:0]       r_sr [SHIFT_REG_LEN];
    logic [CNT_W-1:0] r_count, w_count_next;
    logic [ROW_W-1:0] r_row, w_row_next;
    logic [COL_W-1:0] r_col, w_col_next;
    logic [7:0]       r_result, w_result_next;

    logic             w_pop, w_shift, w_wr_en;
    logic [9:0]       w_shift_data;
    logic [IDX_W-1:0] w_pix_idx;
    logic [7:0]       w_mag_c, w_mag_a, w_mag_b, w_nms_val;
    logic             w_keep, w_border;

    // Linear index of the pixel that the next NMS shift will evaluate.
    assign w_pix_idx = IDX_W'(r_row) * IDX_W'(WIDTH) + IDX_W'(r_col);

    // Once the last real word is in, zero padding pushes the final rows through the centre.
    always_comb begin
        w_pop        = 1'b0;
        w_shift      = 1'b0;
        w_shift_data = 10'h000;
        if (r_state == S_PROLOGUE || r_state == S_NMS) begin
            if (!bus.in_empty) begin
                w_pop        = 1'b1;
                w_shift      = 1'b1;
                w_shift_data = bus.in_dout;
            end else if (w_pix_idx > IDX_W'(PAD_START)) begin
                w_shift = 1'b1;
            end
        end
    end

    assign w_mag_c = r_sr[WIDTH+1][7:0];

    always_comb begin
        w_mag_a = 8'h00;
        w_mag_b = 8'h00;
        case (r_sr[WIDTH+1][9:8])
            2'd0: begin w_mag_a = r_sr[WIDTH][7:0];   w_mag_b = r_sr[WIDTH+2][7:0];   end
            2'd1: begin w_mag_a = r_sr[2][7:0];       w_mag_b = r_sr[2*WIDTH][7:0];   end
            2'd2: begin w_mag_a = r_sr[1][7:0];       w_mag_b = r_sr[2*WIDTH+1][7:0]; end
            default: begin w_mag_a = r_sr[0][7:0];    w_mag_b = r_sr[2*WIDTH+2][7:0]; end
        endcase
    end

`ifdef NMS_STRICT_EN
    assign w_keep = (w_mag_c > w_mag_a) && (w_mag_c > w_mag_b);
`else
    assign w_keep = (w_mag_c >= w_mag_a) && (w_mag_c >= w_mag_b);
`endif

    assign w_border  = (r_row == '0) || (r_row == ROW_W'(HEIGHT - 1)) ||
                       (r_col == '0) || (r_col == COL_W'(WIDTH - 1));
    assign w_nms_val = (w_keep && !w_border) ? w_mag_c : 8'h00;

    always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_row_next    = r_row;
        w_col_next    = r_col;
        w_result_next = r_result;
        w_wr_en       = 1'b0;
        case (r_state)
            S_PROLOGUE: begin
                if (w_shift) begin
                    w_count_next = r_count + 1'b1;
                    if (r_count == CNT_W'(WIDTH + 1))
                        w_state_next = S_NMS;
                end
            end
            S_NMS: begin
                if (w_shift) begin
                    w_result_next = w_nms_val;
                    if (r_col == COL_W'(WIDTH - 1)) begin
                        w_col_next = '0;
                        w_row_next = r_row + 1'b1;
                    end else begin
                        w_col_next = r_col + 1'b1;
                    end
                    w_state_next = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (!bus.out_full) begin
                    w_wr_en = 1'b1;
                    // row has already stepped past the last line once the final pixel is pending
                    if (r_row == ROW_W'(HEIGHT)) begin
                        w_state_next  = S_PROLOGUE;
                        w_count_next  = '0;
                        w_row_next    = '0;
                        w_col_next    = '0;
                        w_result_next = 8'h00;
                    end else begin
                        w_state_next = S_NMS;
                    end
                end
            end
            default: w_state_next = S_PROLOGUE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_PROLOGUE;
            r_count  <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_result <= 8'h00;
        end else begin
            r_state  <= w_state_next;
            r_count  <= w_count_next;
            r_row    <= w_row_next;
            r_col    <= w_col_next;
            r_result <= w_result_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SHIFT_REG_LEN; i++)
                r_sr[i] <= 10'h000;
        end else if (w_shift) begin
            for (int i = 0; i < SHIFT_REG_LEN - 1; i++)
                r_sr[i] <= r_sr[i+1];
            r_sr[SHIFT_REG_LEN-1] <= w_shift_data;
        end
    end

    assign bus.in_rd_en  = w_pop;
    assign bus.out_wr_en = w_wr_en;
    assign bus.out_din   = r_result;
endmodule

// File: tb/tb_non_max_suppression.sv
// Directed bench for non_max_suppression on a 5x4 image with hand-computed expected frames.
module tb_non_max_suppression;
    localparam int W = 5;
    localparam int H = 4;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    non_max_suppression_if bus();

    non_max_suppression #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [9:0] q_in[$];
    logic [7:0] q_out[$];
    logic [7:0] q_exp[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_cols(input logic [1:0] dir, input logic [7:0] c0, c1, c2, c3, c4);
        logic [7:0] m[5];
        m = '{c0, c1, c2, c3, c4};
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                q_in.push_back({dir, m[c]});
    endtask

    // Interior rows take the given values; top and bottom rows are border and must be zero.
    task automatic exp_rows(input logic [7:0] c0, c1, c2, c3, c4);
        logic [7:0] m[5];
        m = '{c0, c1, c2, c3, c4};
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                q_exp.push_back((r == 0 || r == H - 1) ? 8'h00 : m[c]);
    endtask

    task automatic run_frame(input bit bubbles, input bit stall, input int stop_after, output int n_out);
        int cyc, full_cnt, pops, pop_last_cyc, push1_cyc;
        bit both, wr_in_full;
        logic [7:0] held;
        n_out = 0; cyc = 0; full_cnt = 0; pops = 0;
        pop_last_cyc = -1; push1_cyc = -1;
        both = 1'b0; wr_in_full = 1'b0; held = 8'h00;
        while (n_out < N && (stop_after == 0 || n_out < stop_after) && cyc < 2000) begin
            @(negedge clk);
            bus.in_empty = (q_in.size() == 0) || (bubbles && (cyc % 2 == 1));
            bus.in_dout  = (q_in.size() != 0) ? q_in[0] : 10'h000;
            bus.out_full = stall && (n_out == 5) && (full_cnt < 10);
            #1;
            if (bus.out_full) begin
                full_cnt++;
                if (bus.out_wr_en) wr_in_full = 1'b1;
                if (full_cnt == 3) held = bus.out_din;
                if (full_cnt == 10) begin
                    chk("stall_dout_stable", bus.out_din, held);
                    chk("stall_rd_en", bus.in_rd_en, 0);
                end
            end
            if (bus.in_rd_en && bus.out_wr_en) both = 1'b1;
            if (bus.in_rd_en && q_in.size() != 0) begin
                void'(q_in.pop_front());
                pops++;
                if (pops == W + 2) pop_last_cyc = cyc;
            end
            if (bus.out_wr_en && !bus.out_full) begin
                q_out.push_back(bus.out_din);
                if (n_out == 0) push1_cyc = cyc;
                n_out++;
            end
            cyc++;
        end
        bus.out_full = 1'b0;
        chk("timeout", (cyc >= 2000), 0);
        chk("pop_push_exclusive", both, 0);
        if (stop_after == 0) chk("first_push_latency_ge2", ((push1_cyc - pop_last_cyc) >= 2), 1);
        if (stall) chk("stall_no_wr_en", wr_in_full, 0);
    endtask

    task automatic idle_check(input string name);
        bit extra;
        extra = 1'b0;
        repeat (6) begin
            @(negedge clk);
            bus.in_empty = 1'b1;
            #1;
            if (bus.out_wr_en || bus.in_rd_en) extra = 1'b1;
        end
        chk($sformatf("%s_idle_after_frame", name), extra, 0);
    endtask

    task automatic run_and_check(input string name, input bit bubbles, input bit stall);
        int n;
        run_frame(bubbles, stall, 0, n);
        chk($sformatf("%s_count", name), n, N);
        for (int i = 0; i < N; i++)
            chk($sformatf("%s_px%0d", name, i), (i < q_out.size()) ? q_out[i] : 8'hxx, q_exp[i]);
        $display("frame %s: %0d pushes checked", name, n);
        idle_check(name);
        q_out.delete();
        q_exp.delete();
        q_in.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        bus.in_empty = 1'b1;
        bus.in_dout  = 10'h000;
        bus.out_full = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_rd_en", bus.in_rd_en, 0);
        chk("reset_wr_en", bus.out_wr_en, 0);
        chk("reset_dout", bus.out_din, 0);
        @(negedge clk);
        rst = 1'b0;

        load_cols(2'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        exp_rows(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        run_and_check("zero", 1'b0, 1'b0);

        load_cols(2'd0, 8'd10, 8'd50, 8'd100, 8'd50, 8'd10);
        exp_rows(8'd0, 8'd0, 8'd100, 8'd0, 8'd0);
        run_and_check("ridge", 1'b0, 1'b0);

        load_cols(2'd0, 8'd0, 8'd80, 8'd80, 8'd80, 8'd0);
`ifdef NMS_STRICT_EN
        exp_rows(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
`else
        exp_rows(8'd0, 8'd80, 8'd80, 8'd80, 8'd0);
`endif
        run_and_check("plateau", 1'b0, 1'b0);

        // Centre (1,2) dir 1: top-right neighbour 70 beats 60.
        for (int i = 0; i < N; i++) begin
            q_in.push_back(10'h000);
            q_exp.push_back(8'h00);
        end
        q_in[7] = {2'd1, 8'd60};
        q_in[3] = {2'd0, 8'd70};
        run_and_check("diag45", 1'b0, 1'b0);

        // Centre (1,2) dir 3: p1=30, p9=40 lose to 60; p3=70 is not on this diagonal.
        for (int i = 0; i < N; i++) begin
            q_in.push_back(10'h000);
            q_exp.push_back(8'h00);
        end
        q_in[7]  = {2'd3, 8'd60};
        q_in[1]  = {2'd0, 8'd30};
        q_in[3]  = {2'd0, 8'd70};
        q_in[13] = {2'd0, 8'd40};
        q_exp[7]  = 8'd60;
        q_exp[13] = 8'd40;
        run_and_check("diag135", 1'b0, 1'b0);

        load_cols(2'd0, 8'd10, 8'd50, 8'd100, 8'd50, 8'd10);
        exp_rows(8'd0, 8'd0, 8'd100, 8'd0, 8'd0);
        run_and_check("stall_bubble", 1'b1, 1'b1);

        // Abort a ridge frame right after its eighth push (pixel 7 = 100 still in the result register).
        load_cols(2'd0, 8'd10, 8'd50, 8'd100, 8'd50, 8'd10);
        exp_rows(8'd0, 8'd0, 8'd100, 8'd0, 8'd0);
        run_frame(1'b0, 1'b0, 8, n);
        chk("abort_count", n, 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("abort_px%0d", i), (i < q_out.size()) ? q_out[i] : 8'hxx, q_exp[i]);
        @(negedge clk);
        rst = 1'b1;
        bus.in_empty = 1'b1;
        #1;
        chk("midreset_dout", bus.out_din, 0);
        chk("midreset_wr_en", bus.out_wr_en, 0);
        chk("midreset_rd_en", bus.in_rd_en, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q_in.delete();
        q_out.delete();
        q_exp.delete();

        load_cols(2'd0, 8'd10, 8'd50, 8'd100, 8'd50, 8'd10);
        exp_rows(8'd0, 8'd0, 8'd100, 8'd0, 8'd0);
        run_and_check("after_reset", 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
